// File: rtl/fetch_stage_pkg.sv
// Package lc_pkg: shared constants and helpers for the LEGv8 fetch stage.
// Holds the bubble instruction, branch opcode constants, the B.LT condition
// code, and the sign-extend-and-scale helpers used for branch offsets.
package lc_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [63:0] PC_STEP   = 64'd4;

  // Branch opcodes, MSB-aligned in the instruction word
  localparam logic [5:0]  OP_B      = 6'b000101;
  localparam logic [5:0]  OP_BL     = 6'b100101;
  localparam logic [7:0]  OP_CBZ    = 8'b10110100;
  localparam logic [7:0]  OP_BCOND  = 8'b01010100;
  localparam logic [10:0] OP_BR     = 11'b11010110000;

  // Condition field value for B.LT
  localparam logic [4:0]  COND_LT   = 5'b01011;

  // B/BL immediate: sign-extend imm26 and turn the word offset into bytes
  function automatic logic [63:0] se26_x4(input logic [25:0] imm);
    return {{36{imm[25]}}, imm, 2'b00};
  endfunction

  // CBZ/B.cond immediate: sign-extend imm19 and turn the word offset into bytes
  function automatic logic [63:0] se19_x4(input logic [18:0] imm);
    return {{43{imm[18]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the instruction-memory port and the IF/ID <-> decode
// signals of the fetch stage.
//   master : the fetch stage (drives imem_addr and the IF/ID outputs)
//   slave  : the environment (memory, decoder, hazard unit)
// Signals:
//   imem_addr/imem_rdata          combinational instruction-memory read
//   stall                         hazard unit hold request
//   take_branch/uncond_branch/
//   reg_branch/cond_ok/br_reg_data decode-stage branch controls and data
//   id_instr/id_pc/id_pc_plus4/
//   id_valid                      IF/ID register contents for decode
interface fetch_stage_if;

  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        take_branch;
  logic        uncond_branch;
  logic        reg_branch;
  logic        cond_ok;
  logic [63:0] br_reg_data;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [63:0] id_pc_plus4;
  logic        id_valid;

  modport master (
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid,
    input  imem_rdata, stall, take_branch, uncond_branch, reg_branch,
           cond_ok, br_reg_data
  );

  modport slave (
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid,
    output imem_rdata, stall, take_branch, uncond_branch, reg_branch,
           cond_ok, br_reg_data
  );

endinterface

// File: rtl/fetch_stage_branch_target_gen.sv
// branch_target_gen: combinational branch-target selection for the IF/ID
// instruction.
//   id_pc, id_instr   IF/ID PC and instruction (immediates taken from it)
//   br_reg_data       register value for BR
//   uncond_branch     B/BL: PC-relative imm26
//   reg_branch        BR: register target, low two bits forced to zero
//   target            selected 64-bit redirect address
// With neither control set the instruction is treated as CBZ/B.cond (imm19).
module branch_target_gen
  import lc_pkg::*;
(
  input  logic [63:0] id_pc,
  input  logic [31:0] id_instr,
  input  logic [63:0] br_reg_data,
  input  logic        uncond_branch,
  input  logic        reg_branch,
  output logic [63:0] target
);

  // Opcode bits and the register's byte offset never affect the target
  logic unused_bits_s;
  assign unused_bits_s = ^{id_instr[31:26], br_reg_data[1:0]};

  // Pick the target: register beats unconditional beats conditional
  always_comb begin
    target = id_pc + se19_x4(id_instr[23:5]);
    if (reg_branch) begin
      target = {br_reg_data[63:2], 2'b00};
    end else if (uncond_branch) begin
      target = id_pc + se26_x4(id_instr[25:0]);
    end else begin
      target = id_pc + se19_x4(id_instr[23:5]);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction fetch. Owns the PC, drives the instruction
// memory address, and loads the IF/ID register that feeds decode.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (dominates stall and branches)
//   bus    fetch_stage_if.master: imem port, hazard stall, decode branch
//          controls, IF/ID outputs
// Parameters:
//   RESET_PC    PC loaded on reset
//   DELAY_SLOT  1: instruction after a taken branch executes; 0: squashed
module fetch_stage
  import lc_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter bit          DELAY_SLOT = 1'b1
)
(
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [63:0] pc_r;
  logic [31:0] id_instr_r;
  logic [63:0] id_pc_r;
  logic        id_valid_r;

  logic [63:0] target_s;
  logic        redirect_s;
  logic [63:0] pc_next_s;
  logic [31:0] ifid_instr_next_s;
  logic        ifid_valid_next_s;

  branch_target_gen u_target_gen (
    .id_pc         (id_pc_r),
    .id_instr      (id_instr_r),
    .br_reg_data   (bus.br_reg_data),
    .uncond_branch (bus.uncond_branch),
    .reg_branch    (bus.reg_branch),
    .target        (target_s)
  );

  // Redirect only for a real instruction, so bubbles never branch
  always_comb begin
    redirect_s = bus.take_branch & id_valid_r &
                 (bus.uncond_branch | bus.reg_branch | bus.cond_ok);
  end

  // Next PC and next IF/ID contents for an unstalled edge
  always_comb begin
    pc_next_s         = pc_r + PC_STEP;
    ifid_instr_next_s = bus.imem_rdata;
    ifid_valid_next_s = 1'b1;
    if (redirect_s) begin
      pc_next_s = target_s;
      if (DELAY_SLOT) begin
        ifid_instr_next_s = bus.imem_rdata;
        ifid_valid_next_s = 1'b1;
      end else begin
        // Squash the fall-through fetch into a safe all-zero bubble
        ifid_instr_next_s = NOP_INSTR;
        ifid_valid_next_s = 1'b0;
      end
    end else begin
      pc_next_s = pc_r + PC_STEP;
    end
  end

  // PC and IF/ID register: reset, then stall hold, then advance
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      id_instr_r <= NOP_INSTR;
      id_pc_r    <= 64'h0;
      id_valid_r <= 1'b0;
    end else if (bus.stall) begin
      // Holding IF/ID makes a pending branch re-evaluate next cycle
      pc_r       <= pc_r;
      id_instr_r <= id_instr_r;
      id_pc_r    <= id_pc_r;
      id_valid_r <= id_valid_r;
    end else begin
      pc_r       <= pc_next_s;
      id_instr_r <= ifid_instr_next_s;
      id_pc_r    <= pc_r;
      id_valid_r <= ifid_valid_next_s;
    end
  end

  assign bus.imem_addr   = pc_r;
  assign bus.id_instr    = id_instr_r;
  assign bus.id_pc       = id_pc_r;
  assign bus.id_valid    = id_valid_r;
  assign bus.id_pc_plus4 = id_pc_r + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: two instances (DELAY_SLOT=0 on bus0,
// DELAY_SLOT=1 on bus1) share stimulus; directed scenarios check fixed
// values, and a random run checks every cycle against a reference model.
module tb_fetch_stage;
  import lc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus0 ();
  fetch_stage_if bus1 ();

  fetch_stage #(.RESET_PC(64'h0), .DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  fetch_stage #(.RESET_PC(64'h0), .DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  int total = 0;
  int bad   = 0;

  // Program overrides; any other address returns an address-tagged word
  logic [31:0] prog [logic [63:0]];

  // Reference model state, index 0 = no delay slot, 1 = delay slot
  logic [63:0] m_pc    [0:1];
  logic [31:0] m_instr [0:1];
  logic [63:0] m_idpc  [0:1];
  logic        m_valid [0:1];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (prog.exists(a)) return prog[a];
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  task automatic model_step(input int k, input logic rst, input logic st,
                            input logic tkb, input logic unc, input logic rg,
                            input logic ok, input logic [63:0] brd);
    logic [31:0] word;
    logic [63:0] tgt;
    longint      off;
    if (rst) begin
      m_pc[k] = 64'h0; m_instr[k] = 32'h0; m_idpc[k] = 64'h0; m_valid[k] = 1'b0;
    end else if (!st) begin
      word = mem_word(m_pc[k]);
      if (tkb && m_valid[k] && (unc || rg || ok)) begin
        if (rg) begin
          tgt = brd - (brd % 64'd4);
        end else if (unc) begin
          off = longint'(m_instr[k][25:0]);
          if (off >= 64'sd33554432) off = off - 64'sd67108864;
          tgt = m_idpc[k] + 64'(off * 64'sd4);
        end else begin
          off = longint'(m_instr[k][23:5]);
          if (off >= 64'sd262144) off = off - 64'sd524288;
          tgt = m_idpc[k] + 64'(off * 64'sd4);
        end
        m_idpc[k]  = m_pc[k];
        m_instr[k] = (k == 1) ? word : 32'h0;
        m_valid[k] = (k == 1);
        m_pc[k]    = tgt;
      end else begin
        m_idpc[k]  = m_pc[k];
        m_instr[k] = word;
        m_valid[k] = 1'b1;
        m_pc[k]    = m_pc[k] + 64'd4;
      end
    end
  endtask

  // Drive one cycle of inputs (shortly after an edge), step the model,
  // then advance to just after the next rising edge.
  task automatic drive_cycle(input logic rst, input logic st, input logic tkb,
                             input logic unc, input logic rg, input logic ok,
                             input logic [63:0] brd);
    reset = rst;
    bus0.stall = st;  bus0.take_branch = tkb; bus0.uncond_branch = unc;
    bus0.reg_branch = rg; bus0.cond_ok = ok; bus0.br_reg_data = brd;
    bus1.stall = st;  bus1.take_branch = tkb; bus1.uncond_branch = unc;
    bus1.reg_branch = rg; bus1.cond_ok = ok; bus1.br_reg_data = brd;
    bus0.imem_rdata = mem_word(bus0.imem_addr);
    bus1.imem_rdata = mem_word(bus1.imem_addr);
    for (int k = 0; k < 2; k++) model_step(k, rst, st, tkb, unc, rg, ok, brd);
    @(posedge clk);
    #1;
  endtask

  task automatic normal(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic restart();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_reset();
    prog.delete();
    for (int i = 0; i < 2; i++) begin
      // Branch controls and stall asserted too: reset must win
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0);
      total++; if (bus0.id_valid !== 1'b0 || bus1.id_valid !== 1'b0) begin bad++;
        $display("FAIL rst_valid: got %b/%b want 0/0", bus0.id_valid, bus1.id_valid); end
      total++; if (bus1.imem_addr !== 64'h0 || bus1.id_pc !== 64'h0 || bus1.id_instr !== 32'h0) begin bad++;
        $display("FAIL rst_state: got pc=%h id_pc=%h instr=%h want 0", bus1.imem_addr, bus1.id_pc, bus1.id_instr); end
    end
    normal(1);
    total++; if (bus1.id_pc !== 64'h0 || bus1.imem_addr !== 64'h4 || bus1.id_valid !== 1'b1) begin bad++;
      $display("FAIL first_fetch: got id_pc=%h pc=%h v=%b want 0/4/1", bus1.id_pc, bus1.imem_addr, bus1.id_valid); end
    total++; if (bus1.id_instr !== 32'hC0DE_0000) begin bad++;
      $display("FAIL first_instr: got %h want c0de0000", bus1.id_instr); end
    for (int i = 1; i < 4; i++) begin
      normal(1);
      total++; if (bus0.id_pc !== 64'(4 * i)) begin bad++;
        $display("FAIL seq_id_pc: got %h want %h", bus0.id_pc, 64'(4 * i)); end
    end
  endtask

  task automatic test_b_forward();
    prog.delete();
    prog[64'h10] = {OP_B, 26'd3};
    restart();
    normal(5);
    total++; if (bus1.id_pc !== 64'h10 || bus1.id_instr !== {OP_B, 26'd3}) begin bad++;
      $display("FAIL b_setup: got id_pc=%h instr=%h want 10/%h", bus1.id_pc, bus1.id_instr, {OP_B, 26'd3}); end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    total++; if (bus1.imem_addr !== 64'h1C) begin bad++;
      $display("FAIL b_target: got %h want 1c", bus1.imem_addr); end
    total++; if (bus1.id_pc !== 64'h14 || bus1.id_valid !== 1'b1 || bus1.id_instr !== 32'hC0DE_0014) begin bad++;
      $display("FAIL b_delay_slot: got id_pc=%h v=%b instr=%h want 14/1/c0de0014", bus1.id_pc, bus1.id_valid, bus1.id_instr); end
    total++; if (bus0.id_valid !== 1'b0 || bus0.id_instr !== 32'h0) begin bad++;
      $display("FAIL b_squash: got v=%b instr=%h want 0/0", bus0.id_valid, bus0.id_instr); end
    normal(1);
    total++; if (bus1.id_pc !== 64'h1C || bus1.imem_addr !== 64'h20) begin bad++;
      $display("FAIL b_resume: got id_pc=%h pc=%h want 1c/20", bus1.id_pc, bus1.imem_addr); end
  endtask

  task automatic test_cbz();
    prog.delete();
    prog[64'h40] = {OP_CBZ, 19'h7FFFE, 5'd0};
    restart();
    normal(17);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0);
    total++; if (bus0.imem_addr !== 64'h38) begin bad++;
      $display("FAIL cbz_target: got %h want 38", bus0.imem_addr); end
    total++; if (bus0.id_instr !== 32'h0 || bus0.id_valid !== 1'b0) begin bad++;
      $display("FAIL cbz_flush: got instr=%h v=%b want 0/0", bus0.id_instr, bus0.id_valid); end
    // Branch controls against a bubble must not redirect
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0);
    total++; if (bus0.imem_addr !== 64'h3C) begin bad++;
      $display("FAIL bubble_branch: got %h want 3c", bus0.imem_addr); end
    // Not-taken B.LT proceeds sequentially without a flush
    prog.delete();
    prog[64'h40] = {OP_BCOND, 19'd5, COND_LT};
    restart();
    normal(17);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    total++; if (bus0.imem_addr !== 64'h48 || bus0.id_valid !== 1'b1 || bus0.id_pc !== 64'h44) begin bad++;
      $display("FAIL blt_not_taken: got pc=%h v=%b id_pc=%h want 48/1/44", bus0.imem_addr, bus0.id_valid, bus0.id_pc); end
  endtask

  task automatic test_br_bl();
    prog.delete();
    prog[64'h100] = {OP_BL, 26'h3FF_FFFC};
    restart();
    normal(1);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h1237);
    total++; if (bus0.imem_addr !== 64'h1234 || bus1.imem_addr !== 64'h1234) begin bad++;
      $display("FAIL br_align: got %h/%h want 1234", bus0.imem_addr, bus1.imem_addr); end
    normal(1);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h103);
    normal(1);
    total++; if (bus1.id_pc_plus4 !== 64'h104 || bus1.id_instr !== {OP_BL, 26'h3FF_FFFC}) begin bad++;
      $display("FAIL bl_link: got plus4=%h instr=%h want 104/%h", bus1.id_pc_plus4, bus1.id_instr, {OP_BL, 26'h3FF_FFFC}); end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    total++; if (bus1.imem_addr !== 64'hF0) begin bad++;
      $display("FAIL bl_back: got %h want f0", bus1.imem_addr); end
  endtask

  task automatic test_stall();
    prog.delete();
    prog[64'h10] = {OP_B, 26'd3};
    restart();
    normal(5);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      total++; if (bus1.imem_addr !== 64'h14 || bus1.id_pc !== 64'h10 || bus1.id_valid !== 1'b1) begin bad++;
        $display("FAIL stall_hold: got pc=%h id_pc=%h v=%b want 14/10/1", bus1.imem_addr, bus1.id_pc, bus1.id_valid); end
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
    total++; if (bus1.imem_addr !== 64'h1C || bus1.id_pc !== 64'h14) begin bad++;
      $display("FAIL stall_release: got pc=%h id_pc=%h want 1c/14", bus1.imem_addr, bus1.id_pc); end
  endtask

  task automatic test_wrap();
    prog.delete();
    restart();
    normal(1);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    total++; if (bus1.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++;
      $display("FAIL wrap_setup: got %h want fffffffffffffffc", bus1.imem_addr); end
    normal(1);
    total++; if (bus1.imem_addr !== 64'h0 || bus1.id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus1.id_pc_plus4 !== 64'h0) begin bad++;
      $display("FAIL wrap: got pc=%h id_pc=%h plus4=%h want 0/fffffffffffffffc/0", bus1.imem_addr, bus1.id_pc, bus1.id_pc_plus4); end
  endtask

  task automatic test_random();
    logic        rst, st, tkb, unc, rg, ok;
    logic [63:0] brd;
    logic [63:0] a_pc, a_idpc, a_p4;
    logic [31:0] a_instr;
    logic        a_valid;
    prog.delete();
    prog[64'h20] = {OP_CBZ, 19'h7FFF0, 5'd3};
    prog[64'h80] = {OP_B, 26'h3FF_FFE0};
    restart();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(99, 0) < 2);
      st  = ($urandom_range(99, 0) < 20);
      tkb = ($urandom_range(99, 0) < 35);
      unc = ($urandom_range(99, 0) < 30);
      rg  = ($urandom_range(99, 0) < 15);
      ok  = ($urandom_range(99, 0) < 50);
      brd = {$urandom, $urandom} & 64'h0000_0000_0000_0FFF;
      drive_cycle(rst, st, tkb, unc, rg, ok, brd);
      for (int k = 0; k < 2; k++) begin
        a_pc    = (k == 0) ? bus0.imem_addr   : bus1.imem_addr;
        a_idpc  = (k == 0) ? bus0.id_pc       : bus1.id_pc;
        a_p4    = (k == 0) ? bus0.id_pc_plus4 : bus1.id_pc_plus4;
        a_instr = (k == 0) ? bus0.id_instr    : bus1.id_instr;
        a_valid = (k == 0) ? bus0.id_valid    : bus1.id_valid;
        total++; if (a_pc !== m_pc[k]) begin bad++;
          $display("FAIL rand_pc[%0d] cyc %0d: got %h want %h", k, c, a_pc, m_pc[k]); end
        total++; if (a_idpc !== m_idpc[k] || a_p4 !== m_idpc[k] + 64'd4) begin bad++;
          $display("FAIL rand_id_pc[%0d] cyc %0d: got %h/%h want %h", k, c, a_idpc, a_p4, m_idpc[k]); end
        total++; if (a_instr !== m_instr[k] || a_valid !== m_valid[k]) begin bad++;
          $display("FAIL rand_ifid[%0d] cyc %0d: got %h/%b want %h/%b", k, c, a_instr, a_valid, m_instr[k], m_valid[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_b_forward();
    test_cbz();
    test_br_bl();
    test_stall();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 pipeline, directly upstream of decode.
- Holds the PC and drives the instruction-memory address.
- Registers the fetched instruction and its PC into the IF/ID register that feeds the decoder.
- Resolves PC redirection for B, BL, BR, CBZ and B.LT using decode-stage branch controls and a condition result. Branch targets are computed here from the IF/ID instruction.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- DELAY_SLOT, 1, 1: the instruction after a taken branch executes (one delay slot). 0: that instruction is squashed.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  64  current PC to instruction memory (combinational read).
- imem_rdata  in  32  instruction at imem_addr, same cycle.
- stall  in  1  from hazard unit: hold PC and IF/ID.
- take_branch  in  1  decode control: the IF/ID instruction is a branch.
- uncond_branch  in  1  decode control: B/BL.
- reg_branch  in  1  decode control: BR.
- cond_ok  in  1  decode condition: CBZ operand zero, or B.LT flags N!=V. Ignored for unconditional branches.
- br_reg_data  in  64  Reg[Rd] read data for BR.
- id_instr  out  32  IF/ID instruction to the decoder.
- id_pc  out  64  IF/ID PC.
- id_pc_plus4  out  64  id_pc+4, the link value for BL.
- id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset: PC=RESET_PC; id_instr=32'h0; id_pc=0; id_valid=0. 32'h0 decodes to all-default controls, so it is a safe bubble.
- Reset dominates stall and branch. Reset asserted mid-run takes effect at the next edge. Fetch restarts at RESET_PC on the first edge after reset deasserts.
- imem_addr=PC combinationally. Fetch latency is 1 cycle from PC to id_instr.
- redirect = take_branch & id_valid & (uncond_branch | reg_branch | cond_ok).
- Target computation (all arithmetic 64-bit, two's complement, wraps modulo 2^64):
  - reg_branch: target = {br_reg_data[63:2],2'b00}.
  - uncond_branch: target = id_pc + (SE(id_instr[25:0])<<2).
  - otherwise, conditional: target = id_pc + (SE(id_instr[23:5])<<2).
- Sequential PC = PC+4. At PC=64'hFFFF_FFFF_FFFF_FFFC it wraps to 0.
- Each edge, priority order:
  1. reset.
  2. stall: PC, id_instr, id_pc and id_valid all hold. A pending redirect is not taken this cycle; it re-evaluates next cycle because IF/ID is held.
  3. redirect: PC<=target.
     - DELAY_SLOT=1: IF/ID<={imem_rdata, PC, valid=1}.
     - DELAY_SLOT=0: IF/ID<={32'h0, PC, valid=0}.
  4. normal: PC<=PC+4; IF/ID<={imem_rdata, PC, 1}.
- take_branch with cond_ok=0 and neither uncond_branch nor reg_branch set: no redirect, proceed as normal.
- Branch controls are ignored when id_valid=0, so there are no phantom branches from bubbles.
- Back-to-back branches, with a branch sitting in the delay slot: the second branch resolves in its own decode cycle. Its target is relative to its own id_pc.
- id_pc_plus4 = id_pc+4, combinational.

Decomposition:
- Package lc_pkg:
  - NOP_INSTR=32'h0.
  - Opcode constants: B 6'b000101, BL 6'b100101, CBZ 8'b10110100, B.cond 8'b01010100, BR 11'b11010110000.
  - Condition code LT=5'b01011.
  - Functions se26_x4 and se19_x4 returning 64-bit byte offsets.
- Sub-module branch_target_gen: purely combinational. Inputs id_pc, id_instr, br_reg_data, uncond_branch, reg_branch; output target. This keeps the stage's sequential logic separate and lets target generation be unit-tested alone.

Test Plan:
1. Reset then run: reset 2 cycles with RESET_PC=0 and imem returning addr-tagged words -> id_valid=0 during reset. First edge after release gives id_pc=0, PC=4. Then id_pc increments 0,4,8,...
2. B forward, DELAY_SLOT=1: id_instr=B imm26=3 at id_pc=0x10, take_branch=uncond=1 -> PC becomes 0x1C. The instruction at 0x14 reaches IF/ID with id_valid=1. Next id_pc=0x1C.
3. CBZ backward, DELAY_SLOT=0: CBZ imm19=-2 at id_pc=0x40, cond_ok=1 -> PC=0x38. IF/ID gets id_instr=0, id_valid=0. With cond_ok=0 instead -> PC=0x48 and no flush.
4. BR with misaligned register: br_reg_data=0x1237, reg_branch=1 -> PC=0x1234. BL at id_pc=0x100 -> id_pc_plus4=0x104 while the BL is in IF/ID.
5. Stall versus branch: stall=1 for 2 cycles while a taken B is in IF/ID -> PC and IF/ID unchanged for both cycles. The redirect applies on the first unstalled edge, to the same target.
6. Wrap and bubble: PC=0xFFFF_FFFF_FFFF_FFFC -> next PC=0. take_branch=1 with id_valid=0 -> no redirect.
